// File: rtl/log_mult_pkg.sv
// rtl/log_mult_pkg.sv - shared constants and FSM state type for the Mitchell log multiplier
package log_mult_pkg;

  localparam int W    = 16;
  localparam int FRAC = W - 1;
  localparam int PW   = 2 * W;
  localparam int KW   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOD_A   = 3'd1,
    LOD_B   = 3'd2,
    ADD     = 3'd3,
    ANTILOG = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/log_mult_lod_onehot_enc.sv
// rtl/log_mult_lod_onehot_enc.sv - combinational 16-bit one-hot to 4-bit index encoder
module lod_onehot_enc
  import log_mult_pkg::*;
(
  input  logic [W-1:0]  onehot,
  output logic [KW-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) idx = idx | KW'(i);
    end
  end

endmodule

// File: rtl/sixteen_bit_lod.sv
// rtl/sixteen_bit_lod.sv - 16-bit leading-one detector, one-hot output plus all-zero flag
module sixteen_bit_lod (
  input  logic [15:0] data,
  output logic [15:0] onehot,
  output logic        zero
);

  // Scan upward so the highest set bit is the one that survives.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < 16; i++) begin
      if (data[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/log_mult_seq_ctrl.sv
// rtl/log_mult_seq_ctrl.sv - sequencing controller for the Mitchell log multiplier
// Time-shares one LOD between operands, then adds logs and antilog-shifts.
module log_mult_seq_ctrl
  import log_mult_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic          zero_flag,
  output logic          busy
);

  state_t          state;
  logic [W-1:0]    a_reg, b_reg;
  logic [KW-1:0]   ka, kb;
  logic [FRAC-1:0] xa, xb;
  logic            za, zb;
  logic [4:0]      shift;
  logic [W-1:0]    mant;

  logic [W-1:0]    lod_in, lod_onehot;
  logic            lod_zero;
  logic [KW-1:0]   lod_idx;
  logic [FRAC-1:0] lod_x;
  logic [W-1:0]    s_sum;
  logic [46:0]     mant_ext;

  assign lod_in = (state == LOD_B) ? b_reg : a_reg;

  sixteen_bit_lod u_lod (
    .data   (lod_in),
    .onehot (lod_onehot),
    .zero   (lod_zero)
  );

  lod_onehot_enc u_enc (
    .onehot (lod_onehot),
    .idx    (lod_idx)
  );

  // Normalise so the leading one sits at bit 15; the bits below it are the log fraction.
  assign lod_x    = FRAC'(lod_in << (KW'(FRAC) - lod_idx));
  assign s_sum    = {1'b0, xa} + {1'b0, xb};
  assign mant_ext = {31'b0, mant};

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      ka        <= '0;
      kb        <= '0;
      xa        <= '0;
      xb        <= '0;
      za        <= 1'b0;
      zb        <= 1'b0;
      shift     <= '0;
      mant      <= '0;
      product   <= '0;
      zero_flag <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            state <= LOD_A;
          end
        end
        LOD_A: begin
          ka    <= lod_idx;
          xa    <= lod_x;
          za    <= lod_zero;
          state <= LOD_B;
        end
        LOD_B: begin
          kb    <= lod_idx;
          xb    <= lod_x;
          zb    <= lod_zero;
          state <= ADD;
        end
        ADD: begin
          // A fraction carry bumps the exponent; the mantissa keeps only the low fraction bits.
          shift <= {1'b0, ka} + {1'b0, kb} + 5'(s_sum[W-1]);
          mant  <= {1'b1, s_sum[FRAC-1:0]};
          state <= ANTILOG;
        end
        ANTILOG: begin
          product   <= (za | zb) ? '0 : PW'((mant_ext << shift) >> FRAC);
          zero_flag <= za | zb;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_mult_seq_ctrl.sv
// tb/tb_log_mult_seq_ctrl.sv - directed self-checking bench for log_mult_seq_ctrl
module tb_log_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        zero_flag;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  log_mult_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .zero_flag (zero_flag),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Cycle 1 is the period after the acceptance edge; the product should appear in cycle 5.
  task automatic wait_out(input string tag);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd5);
  endtask

  task automatic do_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                       input logic [31:0] exp_p, input logic exp_z);
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; a = oa; b = ob;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " busy"}, {31'b0, busy}, 32'd1);
    wait_out(tag);
    chk({tag, " product"}, product, exp_p);
    chk({tag, " zero_flag"}, {31'b0, zero_flag}, {31'b0, exp_z});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " product hold"}, product, exp_p);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset product", product, 32'd0);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset zero_flag", {31'b0, zero_flag}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("t1 3x5", 16'd3, 16'd5, 32'd14, 1'b0);
    do_op("t2 3x3 carry", 16'd3, 16'd3, 32'd8, 1'b0);
    do_op("t3 max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0000, 1'b0);
    do_op("t4 256x1024", 16'd256, 16'd1024, 32'h0004_0000, 1'b0);
    do_op("t4 zero", 16'd0, 16'd123, 32'd0, 1'b1);

    // Backpressure: hold DONE for 3 cycles while a new request is pending.
    in_valid = 1'b1; a = 16'd3; b = 16'd3;
    @(posedge clk); #1;
    a = 16'd3; b = 16'd5;
    wait_out("t5 stall");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5 stall out_valid", {31'b0, out_valid}, 32'd1);
      chk("t5 stall product", product, 32'd8);
      chk("t5 stall in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t5 idle in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5 next accepted", {31'b0, busy}, 32'd1);
    wait_out("t5 next");
    chk("t5 next product", product, 32'd14);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Async reset mid-operation, while in LOD_B.
    in_valid = 1'b1; a = 16'd255; b = 16'd255;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6 rst busy", {31'b0, busy}, 32'd0);
    chk("t6 rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("t6 rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6 rst product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("t6 7x9", 16'd7, 16'd9, 32'd60, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
